// File: rtl/add_share_arbiter.sv
// Round-robin arbiter sharing one external fixed-latency adder among N_REQ requesters.
// Latency: grant combinational; operands 1 cycle after transfer; response ADD_LAT+2 cycles after transfer.
// Backpressure: a requester holds i_req until granted; no new grants in IDLE or DRAIN.
module add_share_arbiter #(
    parameter int N_REQ   = 4,
    parameter int DATA_W  = 14,
    parameter int ADD_LAT = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      i_enable,
    input  logic [N_REQ-1:0]          i_req,
    input  logic [N_REQ*DATA_W-1:0]   i_data_1,
    input  logic [N_REQ*DATA_W-1:0]   i_data_2,
    output logic [N_REQ-1:0]          o_gnt,
    output logic [DATA_W-1:0]         o_add_a,
    output logic [DATA_W-1:0]         o_add_b,
    output logic                      o_add_valid,
    input  logic [DATA_W:0]           i_add_sum,
    output logic [N_REQ-1:0]          o_rsp_valid,
    output logic [DATA_W:0]           o_rsp_data,
    output logic                      o_idle
);
    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CNT_W = $clog2(ADD_LAT + 3);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

    state_t                          state_q, state_d;
    logic [IDX_W-1:0]                rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]                gnt_idx;
    logic [IDX_W:0]                  cand;
    logic                            xfer;
    logic [CNT_W-1:0]                cnt_q, cnt_d;
    logic [DATA_W-1:0]               add_a_q, add_a_d, add_b_q, add_b_d;
    logic                            add_vld_q, add_vld_d;
    logic [IDX_W-1:0]                add_idx_q, add_idx_d;
    logic [ADD_LAT-1:0]              tag_vld_q, tag_vld_d;
    logic [ADD_LAT-1:0][IDX_W-1:0]   tag_idx_q, tag_idx_d;
    logic [N_REQ-1:0]                rsp_vld_q, rsp_vld_d;
    logic [DATA_W:0]                 rsp_data_q, rsp_data_d;
    logic                            rsp_any;

    // Cyclic search for the first requester at or after rr_ptr, only while running
    always_comb begin
        gnt_idx = '0;
        xfer    = 1'b0;
        cand    = '0;
        if (state_q == S_RUN) begin
            for (int i = 0; i < N_REQ; i++) begin
                cand = {1'b0, rr_ptr_q} + (IDX_W+1)'(i);
                if (cand >= (IDX_W+1)'(N_REQ)) cand = cand - (IDX_W+1)'(N_REQ);
                if (!xfer && i_req[cand[IDX_W-1:0]]) begin
                    xfer    = 1'b1;
                    gnt_idx = cand[IDX_W-1:0];
                end
            end
        end
    end

    assign o_gnt = xfer ? (N_REQ'(1) << gnt_idx) : '0;

    // Operand capture and pointer advance on a transfer; operands hold otherwise
    always_comb begin
        rr_ptr_d  = rr_ptr_q;
        add_a_d   = add_a_q;
        add_b_d   = add_b_q;
        add_vld_d = xfer;
        add_idx_d = add_idx_q;
        if (xfer) begin
            rr_ptr_d  = (gnt_idx == IDX_W'(N_REQ-1)) ? '0 : gnt_idx + IDX_W'(1);
            add_a_d   = i_data_1[gnt_idx*DATA_W +: DATA_W];
            add_b_d   = i_data_2[gnt_idx*DATA_W +: DATA_W];
            add_idx_d = gnt_idx;
        end
    end

    // Requester tag travels alongside the adder so the sum is routed back to its owner
    always_comb begin
        tag_vld_d    = tag_vld_q;
        tag_idx_d    = tag_idx_q;
        tag_vld_d[0] = add_vld_q;
        tag_idx_d[0] = add_idx_q;
        for (int i = 1; i < ADD_LAT; i++) begin
            tag_vld_d[i] = tag_vld_q[i-1];
            tag_idx_d[i] = tag_idx_q[i-1];
        end
        rsp_vld_d  = '0;
        rsp_data_d = rsp_data_q;
        if (tag_vld_q[ADD_LAT-1]) begin
            rsp_vld_d  = N_REQ'(1) << tag_idx_q[ADD_LAT-1];
            rsp_data_d = i_add_sum;
        end
    end

    // In-flight bookkeeping and mode control; DRAIN only retires once nothing is outstanding
    always_comb begin
        rsp_any = |rsp_vld_q;
        cnt_d   = cnt_q;
        if (xfer && !rsp_any)      cnt_d = cnt_q + CNT_W'(1);
        else if (!xfer && rsp_any) cnt_d = cnt_q - CNT_W'(1);
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (i_enable) state_d = S_RUN;
            S_RUN:   if (!i_enable) state_d = S_DRAIN;
            S_DRAIN: begin
                if (i_enable)            state_d = S_RUN;
                else if (cnt_q == '0)    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // All state, cleared asynchronously so in-flight work is discarded on reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            rr_ptr_q   <= '0;
            cnt_q      <= '0;
            add_a_q    <= '0;
            add_b_q    <= '0;
            add_vld_q  <= 1'b0;
            add_idx_q  <= '0;
            tag_vld_q  <= '0;
            tag_idx_q  <= '0;
            rsp_vld_q  <= '0;
            rsp_data_q <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            cnt_q      <= cnt_d;
            add_a_q    <= add_a_d;
            add_b_q    <= add_b_d;
            add_vld_q  <= add_vld_d;
            add_idx_q  <= add_idx_d;
            tag_vld_q  <= tag_vld_d;
            tag_idx_q  <= tag_idx_d;
            rsp_vld_q  <= rsp_vld_d;
            rsp_data_q <= rsp_data_d;
        end
    end

    assign o_add_a     = add_a_q;
    assign o_add_b     = add_b_q;
    assign o_add_valid = add_vld_q;
    assign o_rsp_valid = rsp_vld_q;
    assign o_rsp_data  = rsp_data_q;
    assign o_idle      = (state_q == S_IDLE);
endmodule

// File: doc/add_share_arbiter.md
ADD_SHARE_ARBITER -- requirements
Module: add_share_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 4: number of requesters sharing one adder, range 2..8.
REQ-002 SHALL have parameter DATA_W, default 14: operand width; sum width is DATA_W+1.
REQ-003 SHALL have parameter ADD_LAT, default 1: fixed latency of the external adder, from o_add_valid to the matching i_add_sum, range 1..4.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-006 SHALL have port i_enable, input, 1 bit: allows new grants while high.
REQ-007 SHALL have port i_req, input, N_REQ bits: per-requester request; must stay high with stable operands until granted.
REQ-008 SHALL have port i_data_1, input, N_REQ*DATA_W bits: packed first operands; requester k uses slice [k*DATA_W +: DATA_W].
REQ-009 SHALL have port i_data_2, input, N_REQ*DATA_W bits: packed second operands, same slicing as i_data_1.
REQ-010 SHALL have port o_gnt, output, N_REQ bits: one-hot grant; a transfer occurs when i_req[k] and o_gnt[k] are high in the same cycle.
REQ-011 SHALL have ports o_add_a and o_add_b, output, DATA_W bits each: registered operands to the adder.
REQ-012 SHALL have port o_add_valid, output, 1 bit: marks valid operands on o_add_a and o_add_b.
REQ-013 SHALL have port i_add_sum, input, DATA_W+1 bits: adder result, valid exactly ADD_LAT cycles after o_add_valid.
REQ-014 SHALL have port o_rsp_valid, output, N_REQ bits: one-hot response strobe naming the original requester.
REQ-015 SHALL have port o_rsp_data, output, DATA_W+1 bits: registered sum for the requester flagged on o_rsp_valid.
REQ-016 SHALL have port o_idle, output, 1 bit: high when state is IDLE.

Function
REQ-017 SHALL implement the states IDLE, RUN and DRAIN.
REQ-018 SHALL go IDLE->RUN when i_enable=1, RUN->DRAIN when i_enable=0, DRAIN->RUN when i_enable=1, and DRAIN->IDLE when i_enable=0 and the in-flight count is 0.
REQ-019 SHALL drive o_gnt combinationally, and only in RUN, to the first requesting index at or after rr_ptr, searching cyclically modulo N_REQ.
REQ-020 SHALL drive o_gnt=0 in IDLE and DRAIN, and whenever i_req=0.
REQ-021 SHALL set rr_ptr to (k+1) mod N_REQ after a transfer with requester k, and leave rr_ptr unchanged when no transfer occurs.
REQ-022 SHALL register, on a transfer at cycle t, requester k's operands onto o_add_a and o_add_b and assert o_add_valid during cycle t+1 only.
REQ-023 SHALL hold o_add_valid=0 when no transfer occurs, with o_add_a and o_add_b holding their last values.
REQ-024 SHALL carry requester index k through an internal tag pipeline of depth ADD_LAT aligned to the adder.
REQ-025 SHALL, at cycle t+2+ADD_LAT, drive o_rsp_valid=(1<<k) for one cycle with o_rsp_data set to the i_add_sum captured at cycle t+1+ADD_LAT.
REQ-026 SHALL accept at most one transfer per cycle and SHALL sustain one transfer per cycle, giving full adder throughput.
REQ-027 SHALL keep o_rsp_data at its previous value when no response is valid.
REQ-028 SHALL keep an in-flight counter, width clog2(ADD_LAT+3), that increments on each transfer and decrements on each o_rsp_valid pulse.
REQ-029 SHALL leave the in-flight counter unchanged when a transfer and a response occur in the same cycle.
REQ-030 SHALL pass the sum through unmodified: no width change, saturation or rounding, since fixed-point alignment belongs to the adder.
REQ-031 SHALL deliver every transfer accepted before i_enable falls as a response, and SHALL NOT grant any new transfer while in DRAIN.
REQ-032 SHALL NOT check i_req for protocol violations: a requester that drops i_req before being granted is simply not granted.

Reset
REQ-033 SHALL, on rst=1 and independent of clk, set the state to IDLE, rr_ptr to 0, the in-flight counter to 0, and clear the tag pipeline.
REQ-034 SHALL hold o_gnt=0, o_add_valid=0, o_add_a=0, o_add_b=0, o_rsp_valid=0, o_rsp_data=0 and o_idle=1 while reset is asserted.
REQ-035 SHALL discard operations in flight when reset is asserted mid-operation, with no response emitted for them after reset is released.

Verification
REQ-036 SHALL be checked with a single request: ADD_LAT=1, enable, i_req=0001, data_1[0]=100, data_2[0]=27 -> o_gnt=0001 in the same cycle, o_add_valid one cycle later, o_rsp_valid=0001 with o_rsp_data=127 three cycles after the transfer.
REQ-037 SHALL be checked with round-robin fairness: i_req=1111 held for 8 cycles -> grants 0001, 0010, 0100, 1000, 0001, ... with responses in the same order at one per cycle.
REQ-038 SHALL be checked with a pointer skip: rr_ptr=2, i_req=0011 -> grant 0001, then rr_ptr=1 and the next grant is 0010.
REQ-039 SHALL be checked with a drain: i_enable dropped while 3 operations are in flight and i_req=1111 -> no further grants, 3 responses, then o_idle=1.
REQ-040 SHALL be checked with a signed boundary: DATA_W=14, -8192 + -8192 from requester 3 -> o_rsp_valid=1000, o_rsp_data=-16384 (15-bit).
REQ-041 SHALL be checked with reset mid-operation: rst pulsed with 2 operations in flight -> all outputs 0 and o_idle=1 asynchronously, and no o_rsp_valid pulse after release.
